// File: rtl/ascii_scroll_mux_cc.sv
// Message-buffer feeder for a multiplexed ASCII 7-segment display.
// Each digit slot is one blanking (GUARD) cycle followed by SHOW cycles; the window can optionally scroll.
module ascii_scroll_mux_cc #(
  parameter int N_DIGITS    = 4,
  parameter int MSG_DEPTH   = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 100,
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [AW:0]         msg_len,
  input  logic                start,
  input  logic                stop,
  input  logic                scroll_en,
  output logic [6:0]          ascii_out,
  output logic                dp_out,
  output logic [N_DIGITS-1:0] sel_n,
  output logic                busy,
  output logic                wrap
);

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [7:0]          BLANK    = 8'h20;
  localparam logic [AW:0]         LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]         LEN_MAX  = (AW+1)'(MSG_DEPTH);
  localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 2);
  localparam logic [DW-1:0]       DIG_LAST = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0]       FRM_LAST = FW'(SCROLL_DIV - 1);
  localparam logic [N_DIGITS-1:0] SEL_ONE  = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0] SEL_OFF  = {N_DIGITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t              state_r;
  logic [7:0]          buf_r [MSG_DEPTH];
  logic [AW:0]         len_r;
  logic [AW-1:0]       head_r;
  logic [AW-1:0]       addr_r;
  logic [DW-1:0]       digit_r;
  logic [CW-1:0]       cnt_r;
  logic [FW-1:0]       frame_r;
  logic [6:0]          ascii_r;
  logic                dp_r;
  logic [N_DIGITS-1:0] sel_n_r;
  logic                busy_r;
  logic                wrap_r;

  logic                slot_end_s;
  logic                frame_end_s;
  logic                scroll_step_s;
  logic [AW-1:0]       head_nxt_s;
  logic [AW-1:0]       addr_nxt_s;
  logic [7:0]          rd_char_s;
  logic [AW:0]         len_start_s;

  // Advance a buffer index by one, wrapping at the active message length.
  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a, input logic [AW:0] n);
    logic [AW:0] a_inc;
    a_inc = {1'b0, a} + LEN_ONE;
    if (a_inc == n) begin
      step_addr = '0;
    end else begin
      step_addr = a_inc[AW-1:0];
    end
  endfunction

  // Message buffer: blanks on reset, writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        buf_r[i] <= BLANK;
      end
    end else if (wr_en) begin
      buf_r[wr_addr] <= wr_data;
    end
  end

  // Slot/frame boundary decode and the address of the next digit's character.
  always_comb begin
    slot_end_s    = (state_r == ST_SHOW) && (cnt_r == CNT_LAST);
    frame_end_s   = slot_end_s && (digit_r == DIG_LAST);
    scroll_step_s = frame_end_s && scroll_en && (frame_r == FRM_LAST);
    if (scroll_step_s) begin
      head_nxt_s = step_addr(head_r, len_r);
    end else begin
      head_nxt_s = head_r;
    end
    // A new frame restarts at the (possibly just advanced) head.
    if (frame_end_s) begin
      addr_nxt_s = head_nxt_s;
    end else begin
      addr_nxt_s = step_addr(addr_r, len_r);
    end
    rd_char_s = buf_r[addr_nxt_s];
    if (msg_len == '0) begin
      len_start_s = LEN_ONE;
    end else if (msg_len > LEN_MAX) begin
      len_start_s = LEN_MAX;
    end else begin
      len_start_s = msg_len;
    end
  end

  // Display sequencer with registered decoder and select outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      len_r   <= LEN_ONE;
      head_r  <= '0;
      addr_r  <= '0;
      digit_r <= '0;
      cnt_r   <= '0;
      frame_r <= '0;
      ascii_r <= BLANK[6:0];
      dp_r    <= 1'b0;
      sel_n_r <= SEL_OFF;
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else if (stop) begin
      state_r <= ST_IDLE;
      digit_r <= '0;
      cnt_r   <= '0;
      frame_r <= '0;
      ascii_r <= BLANK[6:0];
      dp_r    <= 1'b0;
      sel_n_r <= SEL_OFF;
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else if (start) begin
      state_r <= ST_GUARD;
      len_r   <= len_start_s;
      head_r  <= '0;
      addr_r  <= '0;
      digit_r <= '0;
      cnt_r   <= '0;
      frame_r <= '0;
      ascii_r <= buf_r[0][6:0];
      dp_r    <= buf_r[0][7];
      sel_n_r <= SEL_OFF;
      busy_r  <= 1'b1;
      wrap_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ascii_r <= BLANK[6:0];
          dp_r    <= 1'b0;
          sel_n_r <= SEL_OFF;
          busy_r  <= 1'b0;
          wrap_r  <= 1'b0;
        end
        ST_GUARD: begin
          state_r <= ST_SHOW;
          cnt_r   <= '0;
          sel_n_r <= ~(SEL_ONE << digit_r);
          wrap_r  <= 1'b0;
        end
        ST_SHOW: begin
          wrap_r <= 1'b0;
          if (slot_end_s) begin
            state_r <= ST_GUARD;
            cnt_r   <= '0;
            addr_r  <= addr_nxt_s;
            ascii_r <= rd_char_s[6:0];
            dp_r    <= rd_char_s[7];
            sel_n_r <= SEL_OFF;
            if (frame_end_s) begin
              digit_r <= '0;
              if (scroll_en) begin
                if (scroll_step_s) begin
                  frame_r <= '0;
                  head_r  <= head_nxt_s;
                  wrap_r  <= (head_nxt_s == '0);
                end else begin
                  frame_r <= frame_r + FW'(1);
                end
              end
            end else begin
              digit_r <= digit_r + DW'(1);
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ascii_r <= BLANK[6:0];
          dp_r    <= 1'b0;
          sel_n_r <= SEL_OFF;
          busy_r  <= 1'b0;
          wrap_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ascii_out = ascii_r;
  assign dp_out    = dp_r;
  assign sel_n     = sel_n_r;
  assign busy      = busy_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_ascii_scroll_mux_cc.sv
// Bench for ascii_scroll_mux_cc: vector table, hand-written corner sequences and a
// randomized run checked against a slot/frame arithmetic model of the display.
module tb_ascii_scroll_mux_cc;

  localparam int ND = 4;
  localparam int MD = 8;
  localparam int RD = 4;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [3:0] msg_len = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       scroll_en = 1'b0;
  logic [6:0] ascii_out;
  logic       dp_out;
  logic [3:0] sel_n;
  logic       busy;
  logic       wrap;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] mem [MD];

  ascii_scroll_mux_cc #(
    .N_DIGITS(ND), .MSG_DEPTH(MD), .REFRESH_DIV(RD), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .scroll_en(scroll_en),
    .ascii_out(ascii_out), .dp_out(dp_out), .sel_n(sel_n), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] len;
    logic       scr;
    int         cyc;
    logic [6:0] ascii;
    logic       dp;
    logic [3:0] sel;
  } tv_t;

  tv_t tv [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge of the first GUARD cycle (t = 0).
  task automatic start_run(input logic [3:0] len, input logic scr);
    msg_len = len; scroll_en = scr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int eff_len(input logic [3:0] len);
    if (len == 4'd0) return 1;
    if (int'(len) > MD) return MD;
    return int'(len);
  endfunction

  // Expected {ascii,dp,sel_n,busy,wrap} t cycles after a start edge, mem stable.
  function automatic logic [13:0] model(input int t, input int L, input logic scr);
    int s, ph, d, f, steps, head, a;
    logic [3:0] sel;
    logic w;
    s = t / RD; ph = t % RD; d = s % ND; f = s / ND;
    steps = scr ? f / SD : 0;
    head = steps % L;
    a = (head + d) % L;
    sel = (ph == 0) ? 4'hF : ~(4'b0001 << d);
    w = scr && (ph == 0) && (d == 0) && (f > 0) && (f % SD == 0) && (head == 0);
    return {mem[a][6:0], mem[a][7], sel, 1'b1, w};
  endfunction

  initial begin
    int wraps;
    int L;
    logic sr;

    tv[0]  = '{4'd4,  1'b0, 0,   7'h48, 1'b0, 4'hF};
    tv[1]  = '{4'd4,  1'b0, 1,   7'h48, 1'b0, 4'hE};
    tv[2]  = '{4'd4,  1'b0, 4,   7'h45, 1'b0, 4'hF};
    tv[3]  = '{4'd4,  1'b0, 5,   7'h45, 1'b0, 4'hD};
    tv[4]  = '{4'd4,  1'b0, 14,  7'h4F, 1'b0, 4'h7};
    tv[5]  = '{4'd4,  1'b0, 17,  7'h48, 1'b0, 4'hE};
    tv[6]  = '{4'd4,  1'b1, 33,  7'h45, 1'b0, 4'hE};
    tv[7]  = '{4'd4,  1'b1, 45,  7'h48, 1'b0, 4'h7};
    tv[8]  = '{4'd2,  1'b0, 9,   7'h48, 1'b0, 4'hB};
    tv[9]  = '{4'd2,  1'b0, 13,  7'h45, 1'b0, 4'h7};
    tv[10] = '{4'd0,  1'b0, 13,  7'h48, 1'b0, 4'h7};
    tv[11] = '{4'd0,  1'b0, 6,   7'h48, 1'b0, 4'hD};
    tv[12] = '{4'd12, 1'b1, 77,  7'h58, 1'b1, 4'h7};
    tv[13] = '{4'd12, 1'b1, 165, 7'h59, 1'b0, 4'hD};
    tv[14] = '{4'd3,  1'b1, 49,  7'h45, 1'b0, 4'hE};
    tv[15] = '{4'd3,  1'b1, 57,  7'h48, 1'b0, 4'hB};

    for (int i = 0; i < MD; i++) mem[i] = 8'h20;

    // Reset state and IDLE outputs
    step(2);
    check("reset_idle", {ascii_out, dp_out, sel_n, busy, wrap}, {7'h20, 1'b0, 4'hF, 1'b0, 1'b0});
    rst_n = 1'b1;
    step(1);
    check("idle_hold", {ascii_out, dp_out, sel_n, busy, wrap}, {7'h20, 1'b0, 4'hF, 1'b0, 1'b0});

    // Asynchronous reset in the middle of SHOW clears buffer and outputs
    write_buf(3'd0, 8'h48);
    write_buf(3'd1, 8'h45);
    start_run(4'd4, 1'b0);
    step(6);
    check("pre_reset_show", {ascii_out, sel_n, busy}, {7'h45, 4'hD, 1'b1});
    rst_n = 1'b0;
    #1;
    check("reset_async", {ascii_out, dp_out, sel_n, busy}, {7'h20, 1'b0, 4'hF, 1'b0});
    for (int i = 0; i < MD; i++) mem[i] = 8'h20;
    step(1);
    rst_n = 1'b1;
    step(1);
    start_run(4'd4, 1'b0);
    step(1);
    check("buf_blank_d0", {ascii_out, dp_out, sel_n}, {7'h20, 1'b0, 4'hE});
    step(4);
    check("buf_blank_d1", {ascii_out, dp_out, sel_n}, {7'h20, 1'b0, 4'hD});

    // Table-driven vectors over a fixed message
    write_buf(3'd0, 8'h48); write_buf(3'd1, 8'h45); write_buf(3'd2, 8'h4C); write_buf(3'd3, 8'h4F);
    write_buf(3'd4, 8'h57); write_buf(3'd5, 8'hD8); write_buf(3'd6, 8'h59); write_buf(3'd7, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      start_run(tv[i].len, tv[i].scr);
      step(tv[i].cyc);
      check($sformatf("vec%0d", i), {ascii_out, dp_out, sel_n, busy},
            {tv[i].ascii, tv[i].dp, tv[i].sel, 1'b1});
    end

    // Scroll wraps back to head 0 exactly once in 8 frames
    start_run(4'd4, 1'b1);
    wraps = 0;
    for (int t = 0; t < 140; t++) begin
      if (wrap === 1'b1) wraps++;
      if (t == 128) check("wrap_at_128", {15'd0, wrap}, 16'd1);
      step(1);
    end
    check("wrap_count", wraps[15:0], 16'd1);

    // start+stop together: stop wins
    start_run(4'd4, 1'b0);
    step(6);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("stop_wins", {ascii_out, dp_out, sel_n, busy, wrap}, {7'h20, 1'b0, 4'hF, 1'b0, 1'b0});
    step(3);
    check("stop_stays", {ascii_out, sel_n, busy}, {7'h20, 4'hF, 1'b0});

    // start while running restarts at buffer[0]
    start_run(4'd4, 1'b0);
    step(10);
    start_run(4'd4, 1'b0);
    check("restart_guard", {ascii_out, dp_out, sel_n, busy}, {7'h48, 1'b0, 4'hF, 1'b1});
    step(1);
    check("restart_show", {ascii_out, sel_n}, {7'h48, 4'hE});

    // Write to buffer[1] during digit 1 SHOW shows up only in the next frame
    start_run(4'd4, 1'b0);
    step(5);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hB7;
    step(1);
    wr_en = 1'b0;
    check("write_same_slot", {ascii_out, dp_out, sel_n}, {7'h45, 1'b0, 4'hD});
    step(15);
    check("write_next_frame", {ascii_out, dp_out, sel_n}, {7'h37, 1'b1, 4'hD});
    write_buf(3'd1, 8'h45);

    // Randomized runs against the arithmetic model
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < MD; a++) write_buf(a[2:0], 8'($urandom));
      msg_len = 4'($urandom_range(0, 15));
      sr = 1'($urandom_range(0, 1));
      L = eff_len(msg_len);
      start_run(msg_len, sr);
      for (int t = 0; t < 180; t++) begin
        check($sformatf("rand%0d_t%0d", r, t), {2'b00, ascii_out, dp_out, sel_n, busy, wrap},
              {2'b00, model(t, L, sr)});
        step(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
